hpu_regf_rd_arbiter: RTL and testbench
======================================

// Module: hpu_regf_rd_arbiter
// PURPOSE
//  Shares the single regfile read-command port between the three processing elements: PEA(0), PEM(1), PEP(2).
//  Enforces a per-requester minimum issue period (PEA/PEM/PEP_REGF_PERIOD budget).
//  Caps each requester's in-flight reads.
//  Sits between the PE instruction front-ends and the regfile read controller; one registered command out per grant.
// PARAMETERS
//  RID_W        6  register-id width (64 regs)
//  PEA_PERIOD   2  min cycles between two PEA grants (>=1)
//  PEM_PERIOD   2  min cycles between two PEM grants (>=1)
//  PEP_PERIOD   1  min cycles between two PEP grants (>=1)
//  OUTSTD_MAX   4  max in-flight reads per requester (>=1)
//  CNT_W        $clog2(max(periods, OUTSTD_MAX)+1), derived, do not override
// PORTS
//  clk          in   1        clock
//  s_rst_n      in   1        asynchronous active-low reset
//  req_vld      in   3        per-requester read-command valid, bit i = requester i
//  req_rdy      out  3        per-requester accept; comb, one-hot or zero
//  req_rid      in   3*RID_W  per-requester register id, slice i
//  rf_vld       out  1        command to regfile valid (registered)
//  rf_rdy       in   1        regfile accepts command
//  rf_src       out  2        requester id of rf command (0 PEA, 1 PEM, 2 PEP)
//  rf_rid       out  RID_W    register id of rf command
//  rsp_done     in   3        pulse: last data word of one read returned to requester i
//  err_underflow out 1        sticky: rsp_done seen with outstanding count 0
// BEHAVIOUR
//  Reset: rf_vld=0, rf_src=0, rf_rid=0, err_underflow=0; all cooldown/outstanding counters 0; rr pointer favours PEA.
//  Per requester i:
//   - cd[i] = cooldown; osd[i] = outstanding count.
//   - elig[i] = req_vld[i] & (cd[i]==0) & (osd[i]<OUTSTD_MAX).
//  Slot free: slot = !rf_vld | rf_rdy. No grant when slot=0; req_rdy=0.
//  Grant selection when slot=1 and any elig:
//   - PEP wins if eligible.
//   - Else round-robin between PEA and PEM.
//   - rr pointer flips to the other one after a PEA or PEM grant; unchanged on a PEP grant.
//  Grant i in cycle N:
//   - req_rdy[i]=1 in N.
//   - rf_vld=1, rf_src=i, rf_rid=req_rid[i] from N+1; 1-cycle latency.
//   - Held stable until rf_rdy.
//  Slot=1 with no elig: rf_vld cleared at next edge if rf_rdy; rf_src/rf_rid keep last value.
//  Back-to-back: with rf_rdy=1 held, one grant per cycle is possible.
//  Cooldown:
//   - On grant of i, cd[i] <= PERIOD_i-1.
//   - Else cd[i] decrements, saturating at 0.
//   - PERIOD=1 allows i granted every cycle.
//  Outstanding osd[i]:
//   - +1 on grant, -1 on rsp_done[i]; both in same cycle -> unchanged.
//   - Increments on grant, not on rf_rdy.
//   - rsp_done[i] with osd[i]==0: counter stays 0, err_underflow<=1 (sticky until reset).
//   - osd[i]==OUTSTD_MAX with a same-cycle rsp_done[i]: not eligible that cycle; eligible next cycle.
//  Requester may drop req_vld without handshake; arbiter never grants a non-valid requester.
//  Reset mid-operation: pending rf command is discarded, counters cleared; no pending state survives.
//  Widths: counters CNT_W bits, never wrap (saturate at 0 / bounded by OUTSTD_MAX).
// TESTING
//  1. All 3 req_vld=1, rf_rdy=1, defaults.
//     -> cyc0 PEP granted, then PEP every cycle.
//     -> PEA/PEM never granted while PEP valid and eligible.
//     -> PEP osd saturates at 4, then PEA, PEM alternate in the cycles PEP is blocked.
//  2. Only PEA/PEM valid, rf_rdy=1, rsp_done returned promptly.
//     -> grants PEA,PEM,PEA,PEM...
//     -> each stream granted every 2 cycles; no stream granted twice within 2 cycles.
//  3. PEP valid, rf_rdy=0 for 5 cycles.
//     -> rf_vld=1 with same rf_src/rf_rid for 5 cycles; req_rdy=0.
//     -> next grant the cycle rf_rdy=1.
//  4. PEM, OUTSTD_MAX=4, no rsp_done.
//     -> exactly 4 grants, then req_rdy[1]=0.
//     -> rsp_done[1] pulse -> one more grant the following cycle.
//  5. rsp_done[0] pulse at reset state -> err_underflow=1 next cycle, osd[0] stays 0.
//     -> a later grant still increments osd[0] to 1.
//  6. Assert s_rst_n=0 while rf_vld=1 and osd=[2,3,1].
//     -> rf_vld=0 immediately (async).
//     -> after release, rr favours PEA and full OUTSTD_MAX credit is available again.

Source files
------------

// File: rtl/hpu_regf_rd_arbiter.sv
// Regfile read-command arbiter for PEA/PEM/PEP: PEP has fixed priority, PEA/PEM share round-robin,
// with per-requester issue cooldown and in-flight read credit. One registered command per grant.
module hpu_regf_rd_arbiter #(
   parameter int RID_W      = 6,
   parameter int PEA_PERIOD = 2,
   parameter int PEM_PERIOD = 2,
   parameter int PEP_PERIOD = 1,
   parameter int OUTSTD_MAX = 4
) (
   input  logic                 clk,
   input  logic                 s_rst_n,
   input  logic [2:0]           req_vld,
   output logic [2:0]           req_rdy,
   input  logic [3*RID_W-1:0]   req_rid,
   output logic                 rf_vld,
   input  logic                 rf_rdy,
   output logic [1:0]           rf_src,
   output logic [RID_W-1:0]     rf_rid,
   input  logic [2:0]           rsp_done,
   output logic                 err_underflow
);

   localparam int P01   = (PEA_PERIOD > PEM_PERIOD) ? PEA_PERIOD : PEM_PERIOD;
   localparam int P012  = (P01 > PEP_PERIOD) ? P01 : PEP_PERIOD;
   localparam int CMAX  = (P012 > OUTSTD_MAX) ? P012 : OUTSTD_MAX;
   localparam int CNT_W = $clog2(CMAX + 1);
   localparam logic [CNT_W-1:0] OSD_MAX_C = CNT_W'(OUTSTD_MAX);

   logic [2:0]       elig;
   logic [2:0]       gnt;
   logic [2:0]       udf;
   logic             slot;
   logic             rr_q, rr_d;
   logic             rf_vld_q, rf_vld_d;
   logic [1:0]       rf_src_q, rf_src_d;
   logic [RID_W-1:0] rf_rid_q, rf_rid_d;
   logic             err_q, err_d;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_req
         localparam int PER = (gi == 0) ? PEA_PERIOD : (gi == 1) ? PEM_PERIOD : PEP_PERIOD;
         logic [CNT_W-1:0] cd_q, cd_d;
         logic [CNT_W-1:0] osd_q, osd_d;

         assign elig[gi] = req_vld[gi] & (cd_q == '0) & (osd_q < OSD_MAX_C);
         assign udf[gi]  = rsp_done[gi] & (osd_q == '0);

         always_comb begin
            cd_d = cd_q;
            if (gnt[gi]) begin
               cd_d = CNT_W'(PER - 1);
            end else if (cd_q != '0) begin
               cd_d = cd_q - 1'b1;
            end
         end

         // A response against an empty count is flagged, never allowed to wrap the counter.
         always_comb begin
            osd_d = osd_q;
            case ({gnt[gi], rsp_done[gi]})
               2'b10:   osd_d = osd_q + 1'b1;
               2'b01:   osd_d = (osd_q == '0) ? osd_q : osd_q - 1'b1;
               default: osd_d = osd_q;
            endcase
         end

         always_ff @(posedge clk or negedge s_rst_n) begin
            if (!s_rst_n) begin
               cd_q  <= '0;
               osd_q <= '0;
            end else begin
               cd_q  <= cd_d;
               osd_q <= osd_d;
            end
         end
      end
   endgenerate

   // rr_q = 0 favours PEA, 1 favours PEM.
   always_comb begin
      slot = !rf_vld_q | rf_rdy;
      gnt  = 3'b000;
      if (slot) begin
         if (elig[2]) begin
            gnt = 3'b100;
         end else if (elig[0] && elig[1]) begin
            gnt = rr_q ? 3'b010 : 3'b001;
         end else begin
            gnt = {1'b0, elig[1:0]};
         end
      end
   end

   assign req_rdy = gnt;

   always_comb begin
      rr_d     = rr_q;
      rf_vld_d = rf_vld_q & ~rf_rdy;
      rf_src_d = rf_src_q;
      rf_rid_d = rf_rid_q;
      err_d    = err_q | (|udf);
      if (gnt[0]) begin
         rr_d = 1'b1;
      end else if (gnt[1]) begin
         rr_d = 1'b0;
      end
      if (|gnt) begin
         rf_vld_d = 1'b1;
         case (gnt)
            3'b100: begin
               rf_src_d = 2'd2;
               rf_rid_d = req_rid[2*RID_W +: RID_W];
            end
            3'b010: begin
               rf_src_d = 2'd1;
               rf_rid_d = req_rid[RID_W +: RID_W];
            end
            default: begin
               rf_src_d = 2'd0;
               rf_rid_d = req_rid[0 +: RID_W];
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         rr_q     <= 1'b0;
         rf_vld_q <= 1'b0;
         rf_src_q <= 2'd0;
         rf_rid_q <= '0;
         err_q    <= 1'b0;
      end else begin
         rr_q     <= rr_d;
         rf_vld_q <= rf_vld_d;
         rf_src_q <= rf_src_d;
         rf_rid_q <= rf_rid_d;
         err_q    <= err_d;
      end
   end

   assign rf_vld        = rf_vld_q;
   assign rf_src        = rf_src_q;
   assign rf_rid        = rf_rid_q;
   assign err_underflow = err_q;

endmodule

// File: tb/tb_hpu_regf_rd_arbiter.sv
// Directed bench for hpu_regf_rd_arbiter: priority, round-robin, backpressure, credit,
// underflow and asynchronous reset scenarios with hand-computed expectations.
module tb_hpu_regf_rd_arbiter;
    localparam int RID_W = 6;

    logic               clk = 1'b0;
    logic               s_rst_n;
    logic [2:0]         req_vld;
    logic [2:0]         req_rdy;
    logic [3*RID_W-1:0] req_rid;
    logic               rf_vld;
    logic               rf_rdy;
    logic [1:0]         rf_src;
    logic [RID_W-1:0]   rf_rid;
    logic [2:0]         rsp_done;
    logic               err_underflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hpu_regf_rd_arbiter #(
        .RID_W(RID_W), .PEA_PERIOD(2), .PEM_PERIOD(2), .PEP_PERIOD(1), .OUTSTD_MAX(4)
    ) dut (
        .clk(clk), .s_rst_n(s_rst_n), .req_vld(req_vld), .req_rdy(req_rdy),
        .req_rid(req_rid), .rf_vld(rf_vld), .rf_rdy(rf_rdy), .rf_src(rf_src),
        .rf_rid(rf_rid), .rsp_done(rsp_done), .err_underflow(err_underflow)
    );

    function automatic int idx(input logic [2:0] oh);
        return oh[2] ? 2 : (oh[1] ? 1 : 0);
    endfunction

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        s_rst_n  = 1'b0;
        req_vld  = '0;
        rsp_done = '0;
        rf_rdy   = 1'b1;
        req_rid  = '0;
        repeat (2) @(posedge clk);
        #1 s_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        s_rst_n  = 1'b0;
        req_vld  = '0;
        rsp_done = '0;
        rf_rdy   = 1'b0;
        req_rid  = '0;
        #3;
        checks++;
        if ({rf_vld, rf_src, rf_rid, err_underflow} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got vld=%0b src=%0d rid=%0h err=%0b, want all 0",
                     rf_vld, rf_src, rf_rid, err_underflow);
        end
        do_reset();
        #1;
        checks++;
        if (rf_vld !== 1'b0 || req_rdy !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: got vld=%0b rdy=%b, want 0/000", rf_vld, req_rdy);
        end
        $display("test_reset done");
    endtask

    task automatic test_pep_priority();
        logic [2:0] exp_g [13];
        int k;
        exp_g = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b001,
                  3'b010, 3'b001, 3'b010, 3'b001, 3'b010, 3'b000};
        do_reset();
        req_rid = {6'h2C, 6'h15, 6'h0A};
        req_vld = 3'b111;
        rf_rdy  = 1'b1;
        for (int c = 0; c < 13; c++) begin
            #1;
            checks++;
            if (req_rdy !== exp_g[c]) begin
                errors++;
                $display("FAIL pep_prio_rdy c%0d: got %b want %b", c, req_rdy, exp_g[c]);
            end
            if (c > 0) begin
                k = idx(exp_g[c-1]);
                checks++;
                if (rf_vld !== 1'b1 || rf_src !== 2'(k) || rf_rid !== req_rid[k*RID_W +: RID_W]) begin
                    errors++;
                    $display("FAIL pep_prio_cmd c%0d: got vld=%0b src=%0d rid=%0h want 1/%0d/%0h",
                             c, rf_vld, rf_src, rf_rid, k, req_rid[k*RID_W +: RID_W]);
                end
            end
            $display("pep_prio c%0d rdy=%b rf_vld=%0b src=%0d", c, req_rdy, rf_vld, rf_src);
            next_cyc();
        end
        #1;
        checks++;
        if (rf_vld !== 1'b0 || req_rdy !== 3'b000) begin
            errors++;
            $display("FAIL pep_prio_drain: got vld=%0b rdy=%b want 0/000", rf_vld, req_rdy);
        end
    endtask

    task automatic test_rr_alternate();
        logic [2:0] prev;
        logic [2:0] exp;
        int k;
        do_reset();
        req_rid = {6'h3F, 6'h21, 6'h12};
        req_vld = 3'b011;
        rf_rdy  = 1'b1;
        prev    = 3'b000;
        for (int c = 0; c < 8; c++) begin
            rsp_done = prev;
            exp = (c % 2 == 0) ? 3'b001 : 3'b010;
            #1;
            checks++;
            if (req_rdy !== exp) begin
                errors++;
                $display("FAIL rr_rdy c%0d: got %b want %b", c, req_rdy, exp);
            end
            if (c > 0) begin
                k = idx(prev);
                checks++;
                if (rf_vld !== 1'b1 || rf_src !== 2'(k) || rf_rid !== req_rid[k*RID_W +: RID_W]) begin
                    errors++;
                    $display("FAIL rr_cmd c%0d: got vld=%0b src=%0d rid=%0h want 1/%0d/%0h",
                             c, rf_vld, rf_src, rf_rid, k, req_rid[k*RID_W +: RID_W]);
                end
            end
            $display("rr c%0d rdy=%b", c, req_rdy);
            prev = exp;
            next_cyc();
        end
        req_vld  = 3'b000;
        rsp_done = prev;
        next_cyc();
        rsp_done = 3'b000;
        #1;
        checks++;
        if (err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL rr_no_underflow: got err=%0b want 0", err_underflow);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_vld = 3'b100;
        req_rid = {6'h33, 6'h00, 6'h00};
        rf_rdy  = 1'b0;
        #1;
        checks++;
        if (req_rdy !== 3'b100) begin
            errors++;
            $display("FAIL bp_first_grant: got %b want 100", req_rdy);
        end
        next_cyc();
        req_rid[2*RID_W +: RID_W] = 6'h07;
        for (int c = 1; c <= 5; c++) begin
            #1;
            checks++;
            if (req_rdy !== 3'b000 || {rf_vld, rf_src, rf_rid} !== {1'b1, 2'd2, 6'h33}) begin
                errors++;
                $display("FAIL bp_hold c%0d: got rdy=%b vld=%0b src=%0d rid=%0h want 000/1/2/33",
                         c, req_rdy, rf_vld, rf_src, rf_rid);
            end
            $display("bp c%0d rdy=%b rf_vld=%0b rid=%0h", c, req_rdy, rf_vld, rf_rid);
            next_cyc();
        end
        rf_rdy = 1'b1;
        #1;
        checks++;
        if (req_rdy !== 3'b100 || rf_rid !== 6'h33) begin
            errors++;
            $display("FAIL bp_release: got rdy=%b rid=%0h want 100/33", req_rdy, rf_rid);
        end
        next_cyc();
        #1;
        checks++;
        if (rf_vld !== 1'b1 || rf_rid !== 6'h07) begin
            errors++;
            $display("FAIL bp_new_cmd: got vld=%0b rid=%0h want 1/07", rf_vld, rf_rid);
        end
    endtask

    task automatic test_outstanding();
        logic [2:0] exp_g [10];
        exp_g = '{3'b010, 3'b000, 3'b010, 3'b000, 3'b010, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000};
        do_reset();
        req_rid = {6'h00, 6'h2A, 6'h00};
        req_vld = 3'b010;
        rf_rdy  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++;
            if (req_rdy !== exp_g[c]) begin
                errors++;
                $display("FAIL osd_rdy c%0d: got %b want %b", c, req_rdy, exp_g[c]);
            end
            $display("osd c%0d rdy=%b", c, req_rdy);
            next_cyc();
        end
        rsp_done = 3'b010;
        #1;
        checks++;
        if (req_rdy !== 3'b000) begin
            errors++;
            $display("FAIL osd_full_same_cycle: got %b want 000", req_rdy);
        end
        next_cyc();
        rsp_done = 3'b000;
        #1;
        checks++;
        if (req_rdy !== 3'b010) begin
            errors++;
            $display("FAIL osd_credit_return: got %b want 010", req_rdy);
        end
        for (int c = 12; c < 14; c++) begin
            next_cyc();
            #1;
            checks++;
            if (req_rdy !== 3'b000) begin
                errors++;
                $display("FAIL osd_refull c%0d: got %b want 000", c, req_rdy);
            end
        end
    endtask

    task automatic test_underflow();
        logic [2:0] exp_g [9];
        exp_g = '{3'b001, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000, 3'b000};
        do_reset();
        rsp_done = 3'b001;
        #1;
        checks++;
        if (err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL udf_not_yet: got %0b want 0", err_underflow);
        end
        next_cyc();
        rsp_done = 3'b000;
        #1;
        checks++;
        if (err_underflow !== 1'b1) begin
            errors++;
            $display("FAIL udf_set: got %0b want 1", err_underflow);
        end
        next_cyc();
        req_vld = 3'b001;
        req_rid = {6'h00, 6'h00, 6'h19};
        for (int c = 0; c < 9; c++) begin
            #1;
            checks++;
            if (req_rdy !== exp_g[c]) begin
                errors++;
                $display("FAIL udf_credit c%0d: got %b want %b", c, req_rdy, exp_g[c]);
            end
            $display("udf c%0d rdy=%b err=%0b", c, req_rdy, err_underflow);
            next_cyc();
        end
        #1;
        checks++;
        if (err_underflow !== 1'b1) begin
            errors++;
            $display("FAIL udf_sticky: got %0b want 1", err_underflow);
        end
    endtask

    task automatic test_reset_midop();
        logic [2:0] vld_seq [7];
        logic [2:0] exp_g [7];
        logic [2:0] exp_a;
        vld_seq = '{3'b010, 3'b000, 3'b010, 3'b011, 3'b011, 3'b011, 3'b100};
        exp_g   = '{3'b010, 3'b000, 3'b010, 3'b001, 3'b010, 3'b001, 3'b100};
        do_reset();
        req_rid = {6'h11, 6'h22, 6'h33};
        rf_rdy  = 1'b1;
        for (int c = 0; c < 7; c++) begin
            req_vld = vld_seq[c];
            #1;
            checks++;
            if (req_rdy !== exp_g[c]) begin
                errors++;
                $display("FAIL midop_setup c%0d: got %b want %b", c, req_rdy, exp_g[c]);
            end
            $display("midop c%0d rdy=%b", c, req_rdy);
            next_cyc();
        end
        req_vld = 3'b000;
        rf_rdy  = 1'b0;
        #1;
        checks++;
        if (rf_vld !== 1'b1 || rf_src !== 2'd2) begin
            errors++;
            $display("FAIL midop_pending: got vld=%0b src=%0d want 1/2", rf_vld, rf_src);
        end
        s_rst_n = 1'b0;
        #1;
        checks++;
        if (rf_vld !== 1'b0) begin
            errors++;
            $display("FAIL midop_async_clear: got vld=%0b want 0", rf_vld);
        end
        @(posedge clk);
        #1 s_rst_n = 1'b1;
        req_vld = 3'b011;
        rf_rdy  = 1'b1;
        for (int c = 0; c < 9; c++) begin
            #1;
            checks++;
            exp_a = (c == 8) ? 3'b000 : ((c % 2 == 0) ? 3'b001 : 3'b010);
            if (req_rdy !== exp_a) begin
                errors++;
                $display("FAIL midop_after c%0d: got %b want %b", c, req_rdy, exp_a);
            end
            $display("midop_after c%0d rdy=%b", c, req_rdy);
            next_cyc();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_pep_priority();
        test_rr_alternate();
        test_backpressure();
        test_outstanding();
        test_underflow();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
